psram_qpi_master: RTL and testbench

- Synthesizable host-side QPI PSRAM controller. Converts single-word or burst read/write requests into SPI-init plus QPI command/address/dummy/data sequences on sck/ce_n/dio.
- Sits between the SoC bus bridge and the off-chip PSRAM (or its simulation model).
- Successor to the fixed-format QPI link: dummy count, byte-size writes, burst length and sck divider are parameters.

---
 rtl/psram_qpi_master.sv | 222 ++++++++++++++++++++++
 tb/tb_psram_qpi_master.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_qpi_master.sv
// Host-side QPI PSRAM master. It sends SPI enter-QPI after reset, then turns
// read/write requests into QPI command/address/dummy/data pulse trains.
module psram_qpi_master #(
  parameter int BURST_WORDS = 1,
  parameter int DUMMY_CYC   = 6,
  parameter int CLK_DIV     = 1,
  parameter int CE_GAP      = 2,
  parameter int INIT_QPI    = 1,
  localparam int DW         = 32 * BURST_WORDS
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [23:0]   req_addr,
  input  logic [1:0]    req_size,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          sck,
  output logic          ce_n,
  output logic [3:0]    dio_o,
  output logic [3:0]    dio_oe,
  input  logic [3:0]    dio_i,
  output logic          qpi_mode,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_INIT_CMD, S_INIT_GAP, S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_GAP
  } state_t;

  localparam logic [7:0] INIT_BYTE = 8'h35;
  localparam logic [2:0] DIV_LAST  = 3'(CLK_DIV - 1);
  localparam logic [5:0] GAP_LAST  = 6'(CE_GAP - 1);

  state_t        state_q;
  logic [2:0]    div_q;
  logic [5:0]    cnt_q;
  logic          sck_q, ce_n_q, req_ready_q, resp_valid_q, qpi_mode_q, busy_q;
  logic [3:0]    dio_o_q, dio_oe_q;
  logic [DW-1:0] resp_rdata_q, rbuf_q, wdata_q;
  logic          wr_q;
  logic [23:0]   addr_q;
  logic [1:0]    size_q;

  logic [5:0]    cnt_d;
  logic [5:0]    len_d;
  logic [5:0]    data_len_d;
  logic          last_d;
  logic [3:0]    nib_d;

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign sck        = sck_q;
  assign ce_n       = ce_n_q;
  assign dio_o      = dio_o_q;
  assign dio_oe     = dio_oe_q;
  assign qpi_mode   = qpi_mode_q;
  assign busy       = busy_q;

  // Pulse count of the current phase and the nibble for the following pulse.
  always_comb begin
    cnt_d = cnt_q + 6'd1;
    case (size_q)
      2'd0:    data_len_d = 6'd2;
      2'd1:    data_len_d = 6'd4;
      2'd2:    data_len_d = 6'd8;
      default: data_len_d = 6'(8 * BURST_WORDS);
    endcase
    case (state_q)
      S_INIT_CMD: len_d = 6'd8;
      S_CMD:      len_d = 6'd2;
      S_ADDR:     len_d = 6'd6;
      S_DUMMY:    len_d = 6'(DUMMY_CYC);
      S_DATA:     len_d = data_len_d;
      default:    len_d = 6'd1;
    endcase
    last_d = (cnt_q == len_d - 6'd1);
    nib_d  = '0;
    case (state_q)
      S_INIT_CMD: nib_d = {3'b000, INIT_BYTE[3'd7 - cnt_d[2:0]]};
      S_CMD:      nib_d = wr_q ? 4'h8 : 4'hB;
      S_ADDR: begin
        case (cnt_d[2:0])
          3'd1:    nib_d = addr_q[19:16];
          3'd2:    nib_d = addr_q[15:12];
          3'd3:    nib_d = addr_q[11:8];
          3'd4:    nib_d = addr_q[7:4];
          3'd5:    nib_d = addr_q[3:0];
          default: nib_d = '0;
        endcase
      end
      // Byte order ascending, high nibble first: nibble k sits at position k^1.
      S_DATA:     if (wr_q) nib_d = 4'(wdata_q >> {cnt_d ^ 6'd1, 2'b00});
      default:    nib_d = '0;
    endcase
  end

  // Main sequencer: init, request accept, pulse generation and response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= (INIT_QPI != 0) ? S_INIT_CMD : S_IDLE;
      div_q        <= '0;
      cnt_q        <= '0;
      sck_q        <= 1'b0;
      ce_n_q       <= 1'b1;
      dio_o_q      <= '0;
      dio_oe_q     <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      rbuf_q       <= '0;
      qpi_mode_q   <= 1'b0;
      busy_q       <= (INIT_QPI != 0);
      wr_q         <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_INIT_GAP, S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_q     <= S_IDLE;
            qpi_mode_q  <= 1'b1;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_IDLE: begin
          if (!qpi_mode_q) begin
            qpi_mode_q  <= 1'b1;
            req_ready_q <= 1'b1;
          end else if (req_valid && req_ready_q) begin
            wr_q        <= req_wr;
            addr_q      <= req_addr;
            size_q      <= req_size;
            wdata_q     <= req_wdata;
            rbuf_q      <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_CMD;
            ce_n_q      <= 1'b0;
            sck_q       <= 1'b0;
            dio_oe_q    <= 4'hF;
            dio_o_q     <= req_wr ? 4'h3 : 4'hE;
            cnt_q       <= '0;
            div_q       <= '0;
          end
        end
        default: begin
          if (state_q == S_INIT_CMD && ce_n_q) begin
            // First cycle after reset: open the SPI frame with bit 7 driven.
            ce_n_q   <= 1'b0;
            sck_q    <= 1'b0;
            dio_oe_q <= 4'b0001;
            dio_o_q  <= {3'b000, INIT_BYTE[7]};
            cnt_q    <= '0;
            div_q    <= '0;
          end else if (div_q != DIV_LAST) begin
            div_q <= div_q + 3'd1;
          end else begin
            div_q <= '0;
            sck_q <= ~sck_q;
            if (!sck_q) begin
              if (state_q == S_DATA && !wr_q)
                rbuf_q <= rbuf_q | (DW'(dio_i) << {cnt_q ^ 6'd1, 2'b00});
            end else if (!last_d) begin
              cnt_q   <= cnt_d;
              dio_o_q <= nib_d;
            end else begin
              cnt_q <= '0;
              case (state_q)
                S_INIT_CMD: begin
                  state_q  <= S_INIT_GAP;
                  ce_n_q   <= 1'b1;
                  dio_oe_q <= '0;
                  dio_o_q  <= '0;
                end
                S_CMD: begin
                  state_q <= S_ADDR;
                  dio_o_q <= addr_q[23:20];
                end
                S_ADDR: begin
                  if (!wr_q && DUMMY_CYC != 0) begin
                    state_q  <= S_DUMMY;
                    dio_oe_q <= '0;
                    dio_o_q  <= '0;
                  end else begin
                    state_q <= S_DATA;
                    if (wr_q) begin
                      dio_o_q <= wdata_q[7:4];
                    end else begin
                      dio_oe_q <= '0;
                      dio_o_q  <= '0;
                    end
                  end
                end
                S_DUMMY: state_q <= S_DATA;
                S_DATA: begin
                  state_q      <= S_GAP;
                  ce_n_q       <= 1'b1;
                  dio_oe_q     <= '0;
                  dio_o_q      <= '0;
                  resp_valid_q <= 1'b1;
                  if (!wr_q) resp_rdata_q <= rbuf_q;
                end
                default: state_q <= S_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psram_qpi_master.sv
// Directed bench: u0 (1 word, CLK_DIV=1) and u1 (4-word burst, CLK_DIV=2),
// each with a small PSRAM read model and a pulse/timing monitor.
module tb_psram_qpi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // ---- u0 signals ----
  logic        rst0, valid0, ready0, wr0, resp_valid0, sck0, ce_n0, qpi0, busy0;
  logic [23:0] addr0;
  logic [1:0]  size0;
  logic [31:0] wdata0, rdata0, rd0;
  logic [3:0]  dio_o0, dio_oe0, dio_i0;

  // ---- u1 signals ----
  logic         rst1, valid1, ready1, wr1, resp_valid1, sck1, ce_n1, qpi1, busy1;
  logic [23:0]  addr1;
  logic [1:0]   size1;
  logic [127:0] wdata1, rdata1, rd1;
  logic [3:0]   dio_o1, dio_oe1, dio_i1;

  psram_qpi_master #(.BURST_WORDS(1), .CLK_DIV(1)) u0 (
    .clock(clk), .reset(rst0), .req_valid(valid0), .req_ready(ready0),
    .req_wr(wr0), .req_addr(addr0), .req_size(size0), .req_wdata(wdata0),
    .resp_valid(resp_valid0), .resp_rdata(rdata0), .sck(sck0), .ce_n(ce_n0),
    .dio_o(dio_o0), .dio_oe(dio_oe0), .dio_i(dio_i0), .qpi_mode(qpi0), .busy(busy0)
  );

  psram_qpi_master #(.BURST_WORDS(4), .CLK_DIV(2)) u1 (
    .clock(clk), .reset(rst1), .req_valid(valid1), .req_ready(ready1),
    .req_wr(wr1), .req_addr(addr1), .req_size(size1), .req_wdata(wdata1),
    .resp_valid(resp_valid1), .resp_rdata(rdata1), .sck(sck1), .ce_n(ce_n1),
    .dio_o(dio_o1), .dio_oe(dio_oe1), .dio_i(dio_i1), .qpi_mode(qpi1), .busy(busy1)
  );

  // ---- per-pulse record, indexed by pulse number within a ce_n frame ----
  int rise0 = 0, rise1 = 0, npulse0 = 0, npulse1 = 0;
  logic [3:0] nib0 [0:63];
  logic [3:0] oe0  [0:63];
  logic [3:0] nib1 [0:63];
  logic [3:0] oe1  [0:63];

  always @(posedge sck0 or posedge ce_n0) begin
    if (ce_n0) begin
      if (rise0 != 0) npulse0 = rise0;
      rise0 = 0;
    end else begin
      if (rise0 < 64) begin nib0[rise0] = dio_o0; oe0[rise0] = dio_oe0; end
      rise0 = rise0 + 1;
    end
  end

  always @(posedge sck1 or posedge ce_n1) begin
    if (ce_n1) begin
      if (rise1 != 0) npulse1 = rise1;
      rise1 = 0;
    end else begin
      if (rise1 < 64) begin nib1[rise1] = dio_o1; oe1[rise1] = dio_oe1; end
      rise1 = rise1 + 1;
    end
  end

  // PSRAM read model: data nibble d is returned during pulse 8+6+d.
  function automatic logic [3:0] model_nib(input logic [127:0] mem, input int d, input int nmax);
    if (d < 0 || d >= nmax) return 4'h0;
    return mem[4*(d ^ 1) +: 4];
  endfunction

  assign dio_i0 = (!ce_n0 && dio_oe0 == 4'h0) ? model_nib(128'(rd0), rise0 - 14, 8) : 4'h0;
  assign dio_i1 = (!ce_n1 && dio_oe1 == 4'h0) ? model_nib(rd1, rise1 - 14, 32) : 4'h0;

  // ---- clock-level monitors ----
  int low_run0 = 0, low_len0 = 0, high_run0 = 0, high_min0 = 100000, rv_cyc0 = 0, oe_viol0 = 0;
  int low_run1 = 0, low_len1 = 0, high_run1 = 0, high_min1 = 100000, rv_cyc1 = 0, oe_viol1 = 0;
  bit seen_low0 = 0, seen_low1 = 0;
  int run1 = 0, maxr1 = 0, minr1 = 100000;
  logic prev_sck1 = 1'b0, prev_ce1 = 1'b1;

  always @(posedge clk) begin
    if (ce_n0 === 1'b0) begin
      low_run0++;
      if (high_run0 != 0) begin
        if (seen_low0 && high_run0 < high_min0) high_min0 = high_run0;
        high_run0 = 0;
      end
    end else begin
      if (low_run0 != 0) begin low_len0 = low_run0; low_run0 = 0; seen_low0 = 1; end
      high_run0++;
    end
    if (resp_valid0 === 1'b1) rv_cyc0++;
    if (ce_n0 === 1'b1 && dio_oe0 !== 4'h0) oe_viol0++;

    if (ce_n1 === 1'b0) begin
      low_run1++;
      if (high_run1 != 0) begin
        if (seen_low1 && high_run1 < high_min1) high_min1 = high_run1;
        high_run1 = 0;
      end
    end else begin
      if (low_run1 != 0) begin low_len1 = low_run1; low_run1 = 0; seen_low1 = 1; end
      high_run1++;
    end
    if (resp_valid1 === 1'b1) rv_cyc1++;
    if (ce_n1 === 1'b1 && dio_oe1 !== 4'h0) oe_viol1++;

    // sck run lengths inside each u1 frame
    if (ce_n1 === 1'b0) begin
      if (prev_ce1) begin run1 = 1; maxr1 = 0; minr1 = 100000; end
      else if (sck1 == prev_sck1) run1++;
      else begin
        if (run1 > maxr1) maxr1 = run1;
        if (run1 < minr1) minr1 = run1;
        run1 = 1;
      end
    end else if (prev_ce1 === 1'b0) begin
      if (run1 > maxr1) maxr1 = run1;
      if (run1 < minr1) minr1 = run1;
    end
    prev_ce1  = ce_n1;
    prev_sck1 = sck1;
  end

  // Packs recorded nibbles (or enables), first pulse most significant.
  function automatic logic [127:0] pack(input int inst, input bit sel_oe, input int first, input int cnt);
    logic [127:0] v = '0;
    for (int i = first; i < first + cnt; i++) begin
      if (inst == 0) v = {v[123:0], sel_oe ? oe0[i] : nib0[i]};
      else           v = {v[123:0], sel_oe ? oe1[i] : nib1[i]};
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic req0(input logic wr, input logic [23:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int t;
    @(negedge clk);
    valid0 = 1'b1; wr0 = wr; addr0 = a; size0 = sz; wdata0 = wd;
    t = 0;
    while (!ready0 && t < 1000) begin @(negedge clk); t++; end
    chk("u0_accept", ready0, 1'b1);
    @(posedge clk); #1;
    valid0 = 1'b0;
    t = 0;
    while (!resp_valid0 && t < 2000) begin @(negedge clk); t++; end
    chk("u0_resp", resp_valid0, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic req1(input logic wr, input logic [23:0] a, input logic [1:0] sz, input logic [127:0] wd);
    int t;
    @(negedge clk);
    valid1 = 1'b1; wr1 = wr; addr1 = a; size1 = sz; wdata1 = wd;
    t = 0;
    while (!ready1 && t < 1000) begin @(negedge clk); t++; end
    chk("u1_accept", ready1, 1'b1);
    @(posedge clk); #1;
    valid1 = 1'b0;
    t = 0;
    while (!resp_valid1 && t < 2000) begin @(negedge clk); t++; end
    chk("u1_resp", resp_valid1, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int t;
    rst0 = 1'b1; rst1 = 1'b1;
    valid0 = 1'b0; wr0 = 1'b0; addr0 = '0; size0 = '0; wdata0 = '0; rd0 = '0;
    valid1 = 1'b0; wr1 = 1'b0; addr1 = '0; size1 = '0; wdata1 = '0; rd1 = '0;
    repeat (3) @(negedge clk);

    // Reset state: {sck, ce_n, dio_o, dio_oe, ready, resp_valid, qpi, busy}
    chk("u0_reset_outs", {sck0, ce_n0, dio_o0, dio_oe0, ready0, resp_valid0, qpi0, busy0},
        {1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1});
    chk("u0_reset_rdata", rdata0, 32'h0);
    chk("u1_reset_outs", {sck1, ce_n1, dio_oe1, ready1, qpi1, busy1},
        {1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1});
    rst0 = 1'b0; rst1 = 1'b0;

    // Init on u0: 0x35 MSB first on dio[0], one bit per nibble
    t = 0;
    while (!ready0 && t < 500) begin @(negedge clk); t++; end
    chk("u0_init_ready", ready0, 1'b1);
    chk("u0_init_qpi", qpi0, 1'b1);
    chk("u0_init_pulses", npulse0, 8);
    chk("u0_init_bits", pack(0, 0, 0, 8), 32'h0011_0101);
    chk("u0_init_oe", pack(0, 1, 0, 8), 32'h1111_1111);
    chk("u0_init_low", low_len0, 16);
    chk("u1_still_init", {busy1, ready1}, 2'b10);

    // u1: request raised while still initialising, must wait then run
    req1(1'b1, 24'h000010, 2'd0, 128'hAB);
    chk("u1_wr1B_pulses", npulse1, 10);
    chk("u1_wr1B_nibs", pack(1, 0, 0, 10), 40'h38_0000_10AB);
    chk("u1_wr1B_low", low_len1, 40);
    chk("u1_wr1B_sckrun", {maxr1[7:0], minr1[7:0]}, 16'h0202);

    // 2-byte write: byte0 0xEF then byte1 0xBE, high nibble first
    req1(1'b1, 24'h000012, 2'd1, 128'hBEEF);
    chk("u1_wr2B_pulses", npulse1, 12);
    chk("u1_wr2B_nibs", pack(1, 0, 0, 12), 48'h38_0000_12EF_BE);
    chk("u1_wr2B_low", low_len1, 48);
    chk("u1_wr2B_sckrun", {maxr1[7:0], minr1[7:0]}, 16'h0202);
    chk("u1_gap_min", high_min1 >= 2, 1'b1);

    // u0 4-byte write
    req0(1'b1, 24'h000100, 2'd2, 32'h1122_3344);
    chk("u0_wr4B_pulses", npulse0, 16);
    chk("u0_wr4B_nibs", pack(0, 0, 0, 16), 64'h3800_0100_4433_2211);
    chk("u0_wr4B_oe", pack(0, 1, 0, 16), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("u0_wr4B_low", low_len0, 32);
    chk("u0_wr4B_rvcyc", rv_cyc0, 1);
    chk("u0_gap_min", high_min0 >= 2, 1'b1);

    // u0 4-byte read back through the model
    rd0 = 32'h1122_3344;
    req0(1'b0, 24'h000100, 2'd2, 32'h0);
    chk("u0_rd4B_pulses", npulse0, 22);
    chk("u0_rd4B_hdr", pack(0, 0, 0, 8), 32'hEB00_0100);
    chk("u0_rd4B_tail_oe", pack(0, 1, 8, 14), 128'h0);
    chk("u0_rd4B_tail_dio", pack(0, 0, 8, 14), 128'h0);
    chk("u0_rd4B_low", low_len0, 44);
    chk("u0_rd4B_rdata", rdata0, 32'h1122_3344);
    chk("u0_rd4B_rvcyc", rv_cyc0, 2);

    // u1 full 128-bit burst read, then a 2-byte read (upper bytes zero)
    rd1 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    req1(1'b0, 24'h000200, 2'd3, 128'h0);
    chk("u1_burst_pulses", npulse1, 46);
    chk("u1_burst_hdr", pack(1, 0, 0, 8), 32'hEB00_0200);
    chk("u1_burst_low", low_len1, 184);
    chk("u1_burst_rdata", rdata1, 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0);
    req1(1'b0, 24'h000204, 2'd1, 128'h0);
    chk("u1_rd2B_pulses", npulse1, 18);
    chk("u1_rd2B_rdata", rdata1, 128'hE1F0);
    chk("u1_rvcyc", rv_cyc1, 4);
    chk("oe_when_ce_high", oe_viol0 + oe_viol1, 0);

    // Reset asserted in the DATA phase of a u0 write
    @(negedge clk);
    valid0 = 1'b1; wr0 = 1'b1; addr0 = 24'h000300; size0 = 2'd2; wdata0 = 32'hCAFE_F00D;
    t = 0;
    while (!ready0 && t < 100) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    valid0 = 1'b0;
    t = 0;
    while (rise0 < 10 && t < 500) begin @(negedge clk); t++; end
    chk("u0_reached_data", rise0 >= 10, 1'b1);
    rst0 = 1'b1;
    @(posedge clk); #1;
    chk("u0_abort_outs", {ce_n0, sck0, dio_oe0, resp_valid0, ready0, qpi0, busy0},
        {1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1});
    chk("u0_abort_rdata", rdata0, 32'h0);
    repeat (2) @(negedge clk);
    rst0 = 1'b0;
    t = 0;
    while (!ready0 && t < 500) begin @(negedge clk); t++; end
    chk("u0_reinit_ready", ready0, 1'b1);
    chk("u0_reinit_pulses", npulse0, 8);
    chk("u0_reinit_bits", pack(0, 0, 0, 8), 32'h0011_0101);
    chk("u0_abort_no_resp", rv_cyc0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
